// File: rtl/stream_arb_mux_if.sv
// Stream bundle between N upstream requesters and one shared downstream port.
// The arbiter sits on the slave modport; the traffic source/sink uses master.
interface stream_arb_mux_if #(
  parameter int N   = 4,
  parameter int W   = 64,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [IDW-1:0] out_id;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_id
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_id
  );
endinterface

// File: rtl/stream_arb_mux.sv
// Packet-level round-robin arbiter/mux: a grant is held from the first beat of a
// packet until its last beat is accepted, feeding one registered output stage.
module stream_arb_mux #(
  parameter int N   = 4,
  parameter int W   = 64,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  stream_arb_mux_if.slave   bus,
  output logic [N-1:0]      gnt,
  output logic              busy
);

  typedef enum logic {S_IDLE, S_LOCK} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;
  logic [W-1:0]   out_data_q, out_data_d;
  logic [IDW-1:0] out_id_q, out_id_d;

  logic [N-1:0]   in_ready;
  logic [W-1:0]   sel_data;
  logic [IDW-1:0] winner;
  logic           accept;
  logic           acc_last;
  logic           any_req;

  // Search starts one past the last owner, so the previous owner is tried last.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0] req,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] pick;
    logic [IDW-1:0] ii;
    logic           found;
    int unsigned    idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(last) + k) % N;
      ii  = IDW'(idx);
      if (!found && req[ii]) begin
        pick  = ii;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] oh;
    for (int unsigned i = 0; i < N; i++) begin
      oh[i] = (IDW'(i) == idx);
    end
    return oh;
  endfunction

  // Handshake and datapath selection; in_ready depends only on grant and output stage.
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    if (state_q == S_LOCK) begin
      in_ready = gnt_q & {N{!out_valid_q || bus.out_ready}};
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) begin
        sel_data = sel_data | bus.in_data[i*W +: W];
      end
    end
    accept   = |(bus.in_valid & in_ready);
    acc_last = |(bus.in_last & gnt_q);
    any_req  = enable && (|bus.in_valid);
    winner   = rr_pick(bus.in_valid, ptr_q);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_last_d  = acc_last;
      out_id_d    = ptr_q;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_LOCK;
          gnt_d   = to_onehot(winner);
          ptr_d   = winner;
        end
      end
      S_LOCK: begin
        // Re-arbitrate on the accepted last beat for a bubble-free handover.
        if (accept && acc_last) begin
          if (any_req) begin
            gnt_d = to_onehot(winner);
            ptr_d = winner;
          end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      ptr_q       <= IDW'(N - 1);
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_id    = out_id_q;
  assign gnt           = gnt_q;
  assign busy          = (state_q == S_LOCK);

  // The pointer always names the lock owner, which is what out_id is loaded from.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert ($onehot0(gnt_q));
      assert ($onehot0(in_ready));
      assert (state_q == S_LOCK || gnt_q == '0);
      assert (state_q != S_LOCK || gnt_q == to_onehot(ptr_q));
    end
  end

endmodule
